instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- RV32I instruction encoder: takes an instruction class plus operand fields and assembles the 32-bit instruction word.
- Covers the same ten opcode classes the main decoder recognises.
- Encoded words are buffered in a small FIFO and presented on a valid/ready output port.
- Used by the self-test / debug injection path to feed instruction words into the pipeline's fetch mux.

Parameters:
- DEPTH, 4, output FIFO entries (power of two, ≥2).
- ERRW, 8, width of saturating error counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request can be accepted.
- cls  input  4  class: 0 R, 1 LOAD, 2 STORE, 3 BRANCH, 4 JAL, 5 OPIMM, 6 LUI, 7 SYSTEM, 8 JALR, 9 AUIPC; 10-15 illegal.
- funct3  input  3  funct3 field.
- funct7b5  input  1  instruction bit 30, for R and OPIMM shifts.
- rd, rs1, rs2  input  5 each  register indices.
- imm  input  32  byte-offset immediate, sign-extended value; for LUI/AUIPC the full 32-bit value (upper 20 bits used).
- out_valid  output  1  instr valid.
- out_ready  input  1  consumer accepts.
- instr  output  32  encoded word at FIFO head.
- err  output  1  one-cycle pulse: rejected request.
- err_cnt  output  ERRW  saturating count of rejected requests.

Behaviour:
- Reset (async, reset=0): FIFO emptied, rd/wr pointers and count = 0; out_valid=0, instr=0, err=0, err_cnt=0. An in-flight request is lost. req_ready=1 from the first edge after release.
- req_ready = (count != DEPTH). It depends only on the registered count. There is no same-cycle pass-through when full, even if a pop occurs.
- Accept when req_valid & req_ready. The encoding is combinational from the inputs and written into the FIFO on that edge if legal.
- Latency: with the FIFO empty, out_valid=1 with the word on the cycle after acceptance.
- Pop when out_valid & out_ready. instr always shows the head entry; it is 0 when empty.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Formats, with opcode from class:
  - R: funct7={0,funct7b5,00000}, opcode 0110011.
  - LOAD: I-type, 0000011.
  - STORE: S-type, 0100011.
  - BRANCH: B-type, 1100011.
  - JAL: J-type, 1101111.
  - OPIMM: I-type, 0010011. For funct3 001/101, imm[11:5] is forced to {0,funct7b5,00000} and imm[4:0] is the shamt.
  - LUI: U-type, 0110111.
  - SYSTEM: 0x00000073 if imm[0]=0 (ecall), else 0x00100073 (ebreak).
  - JALR: I-type, funct3 forced to 000, 1100111.
  - AUIPC: U-type, 0010111.
- Unused fields for a format are ignored.
- Illegal class (10-15): the request is accepted (handshake completes) but nothing is pushed. err pulses high for one cycle (registered, the cycle after accept) and err_cnt increments, saturating at all-ones.
- Error and push are mutually exclusive per request.

Optional Feature:
- Macro ENC_RANGE_CHECK_EN.
- Defined: the following also count as errors (dropped, err pulse, err_cnt++):
  - I/S-type imm not representable in 12 signed bits.
  - B-type imm outside ±4 KiB or imm[0]≠0.
  - J-type imm outside ±1 MiB or imm[0]≠0.
  - U-type imm[11:0]≠0.
  - Shift shamt imm[31:5]≠0.
- Undefined: immediates are silently truncated to the format's bits. Only illegal class raises err.

Test Plan:
- After reset, OPIMM funct3=0 rd=1 rs1=0 imm=5, out_ready=1 -> next cycle out_valid=1, instr=0x00500093; the following cycle out_valid=0.
- STORE funct3=2 rs1=3 rs2=2 imm=8 -> 0x0021A423; BRANCH funct3=0 rs1=1 rs2=2 imm=-4 -> 0xFE208EE3.
- JAL rd=1 imm=8 -> 0x008000EF; LUI rd=5 imm=0x12345000 -> 0x123452B7; SYSTEM imm=1 -> 0x00100073.
- Hold out_ready=0 and push 5 requests with DEPTH=4 -> req_ready=0 after the 4th accept. Then set out_ready=1 with req_valid held -> words pop in order, and the 5th request is accepted the cycle after the first pop.
- cls=12 -> handshake completes, err=1 for one cycle, err_cnt=1, out_valid unchanged. Send 300 illegal requests -> err_cnt saturates at 255.
- With ENC_RANGE_CHECK_EN, OPIMM imm=4096 -> err and no push; without the macro -> instr=0x00000093 (truncated). Assert reset mid-stream with 3 entries queued -> out_valid=0, err_cnt=0 immediately.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: RV32I instruction word assembler with an output FIFO.
// Takes an instruction class plus operand fields, builds the 32-bit word
// combinationally and queues it for a valid/ready consumer (fetch mux
// injection path). Requests with an illegal class are consumed but dropped,
// raising a one-cycle err pulse and bumping a saturating error counter.
//
// Build option: define ENC_RANGE_CHECK_EN to also reject immediates that do
// not fit their format (they are dropped and counted as errors). Without it,
// immediates are silently truncated to the bits the format carries.
`timescale 1ns/1ps

module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int ERRW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      cls,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [31:0]     imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     instr,
  output logic            err,
  output logic [ERRW-1:0] err_cnt
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  // Instruction classes as presented on cls
  localparam logic [3:0] CLS_R      = 4'd0;
  localparam logic [3:0] CLS_LOAD   = 4'd1;
  localparam logic [3:0] CLS_STORE  = 4'd2;
  localparam logic [3:0] CLS_BRANCH = 4'd3;
  localparam logic [3:0] CLS_JAL    = 4'd4;
  localparam logic [3:0] CLS_OPIMM  = 4'd5;
  localparam logic [3:0] CLS_LUI    = 4'd6;
  localparam logic [3:0] CLS_SYSTEM = 4'd7;
  localparam logic [3:0] CLS_JALR   = 4'd8;
  localparam logic [3:0] CLS_AUIPC  = 4'd9;

  // Major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // FIFO state
  logic [31:0]     mem [DEPTH];
  logic [PTRW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTRW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNTW-1:0] count_reg, count_next;
  logic            err_reg, err_next;
  logic [ERRW-1:0] err_cnt_reg, err_cnt_next;

  // Encoder outputs
  logic [31:0] enc_word;
  logic        cls_bad;
  logic        range_bad;
  logic        req_bad;
  logic        is_shift;
  logic [11:0] opimm_imm;

  // Handshake qualifiers
  logic accept;
  logic push;
  logic pop;

  // Shifts (slli/srli/srai) carry funct7 in imm[11:5] and shamt in imm[4:0]
  assign is_shift  = (cls == CLS_OPIMM) && (funct3[1:0] == 2'b01);
  assign opimm_imm = is_shift ? {1'b0, funct7b5, 5'b00000, imm[4:0]} : imm[11:0];

  // Assemble the instruction word for the presented class
  always_comb begin
    enc_word = 32'h0;
    cls_bad  = 1'b0;
    case (cls)
      CLS_R:      enc_word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_R};
      CLS_LOAD:   enc_word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
      CLS_STORE:  enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
      CLS_BRANCH: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
      CLS_JAL:    enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      CLS_OPIMM:  enc_word = {opimm_imm, rs1, funct3, rd, OP_OPIMM};
      CLS_LUI:    enc_word = {imm[31:12], rd, OP_LUI};
      CLS_SYSTEM: enc_word = imm[0] ? 32'h0010_0073 : 32'h0000_0073;
      CLS_JALR:   enc_word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      CLS_AUIPC:  enc_word = {imm[31:12], rd, OP_AUIPC};
      default:    cls_bad = 1'b1;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic fits_s12;
  logic fits_s13;
  logic fits_s21;

  // A value fits N signed bits when everything above bit N-2 is a copy of the sign
  assign fits_s12 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits_s13 = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign fits_s21 = (imm[31:20] == '0) || (imm[31:20] == '1);

  // Flag immediates that the selected format cannot carry exactly
  always_comb begin
    range_bad = 1'b0;
    case (cls)
      CLS_LOAD, CLS_STORE, CLS_JALR: range_bad = ~fits_s12;
      CLS_OPIMM:                     range_bad = is_shift ? (imm[31:5] != '0) : ~fits_s12;
      CLS_BRANCH:                    range_bad = ~fits_s13 | imm[0];
      CLS_JAL:                       range_bad = ~fits_s21 | imm[0];
      CLS_LUI, CLS_AUIPC:            range_bad = (imm[11:0] != '0);
      default:                       range_bad = 1'b0;
    endcase
  end
`else
  // Immediates are truncated to the format's bits; nothing to reject
  assign range_bad = 1'b0;
`endif

  assign req_bad = cls_bad | range_bad;

  // Ready depends only on the registered occupancy: no pass-through when full
  assign req_ready = (count_reg != CNTW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign accept    = req_valid & req_ready;
  assign push      = accept & ~req_bad;
  assign pop       = out_valid & out_ready;

  // Head of queue is always visible; forced to zero while empty
  assign instr   = out_valid ? mem[rd_ptr_reg] : 32'h0;
  assign err     = err_reg;
  assign err_cnt = err_cnt_reg;

  // Next-state for pointers, occupancy and error reporting
  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    err_next     = accept & req_bad;
    err_cnt_next = err_cnt_reg;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTRW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTRW'(1);
    end

    case ({push, pop})
      2'b10:   count_next = count_reg + CNTW'(1);
      2'b01:   count_next = count_reg - CNTW'(1);
      default: count_next = count_reg;
    endcase

    if (accept && req_bad && (err_cnt_reg != '1)) begin
      err_cnt_next = err_cnt_reg + ERRW'(1);
    end
  end

  // Control registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      err_reg     <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      err_reg     <= err_next;
      err_cnt_reg <= err_cnt_next;
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= enc_word;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized + directed self-checking bench for instr_encoder.
// A queue-based reference model predicts FIFO contents, err and err_cnt every
// cycle; instruction words are computed arithmetically from the ISA field rules.
`timescale 1ns/1ps

module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int ERRW  = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [3:0]      cls = '0;
  logic [2:0]      funct3 = '0;
  logic            funct7b5 = 1'b0;
  logic [4:0]      rd = '0;
  logic [4:0]      rs1 = '0;
  logic [4:0]      rs2 = '0;
  logic [31:0]     imm = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     instr;
  logic            err;
  logic [ERRW-1:0] err_cnt;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .cls       (cls),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_q[$];
  bit          m_err = 1'b0;
  int          m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Instruction word from the ISA field placement rules
  function automatic logic [31:0] model_word(input int unsigned c, input int unsigned f3,
                                              input int unsigned f7, input int unsigned d,
                                              input int unsigned s1, input int unsigned s2,
                                              input int unsigned u);
    int unsigned ifld;
    case (c)
      0: return (f7 << 30) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 32'h33;
      1: return ((u & 32'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 32'h03;
      2: return (((u >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
                | ((u & 32'h1F) << 7) | 32'h23;
      3: return (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (s2 << 20)
                | (s1 << 15) | (f3 << 12) | (((u >> 1) & 32'hF) << 8)
                | (((u >> 11) & 1) << 7) | 32'h63;
      4: return (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12)
                | (d << 7) | 32'h6F;
      5: begin
        if (f3 == 1 || f3 == 5) ifld = (f7 << 10) | (u & 32'h1F);
        else                    ifld = u & 32'hFFF;
        return (ifld << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 32'h13;
      end
      6: return (u & 32'hFFFFF000) | (d << 7) | 32'h37;
      7: return ((u & 1) != 0) ? 32'h00100073 : 32'h00000073;
      8: return ((u & 32'hFFF) << 20) | (s1 << 15) | (d << 7) | 32'h67;
      9: return (u & 32'hFFFFF000) | (d << 7) | 32'h17;
      default: return 32'h0;
    endcase
  endfunction

  // Whether a request is pushed (legal class, and in range when checking is built in)
  function automatic bit model_ok(input int unsigned c, input int unsigned f3, input logic [31:0] u);
    int s;
    s = $signed(u);
    if (c > 9) return 1'b0;
`ifdef ENC_RANGE_CHECK_EN
    case (c)
      1, 2, 8: return (s >= -2048) && (s <= 2047);
      5: begin
        if (f3 == 1 || f3 == 5) return (u >> 5) == 0;
        return (s >= -2048) && (s <= 2047);
      end
      3: return (s >= -4096) && (s <= 4095) && (u[0] == 1'b0);
      4: return (s >= -1048576) && (s <= 1048575) && (u[0] == 1'b0);
      6, 9: return (u & 32'hFFF) == 0;
      default: return 1'b1;
    endcase
`else
    return (f3 <= 7) && (s == s);
`endif
  endfunction

  // One clock: predict from current inputs, advance, compare all outputs
  task automatic cycle();
    bit          acc, pp, ok;
    logic [31:0] w;
    acc = req_valid && (m_q.size() < DEPTH);
    pp  = (m_q.size() != 0) && out_ready;
    w   = model_word(cls, funct3, funct7b5, rd, rs1, rs2, imm);
    ok  = model_ok(cls, funct3, imm);
    @(posedge clk);
    #1;
    if (pp) void'(m_q.pop_front());
    if (acc && ok) m_q.push_back(w);
    m_err = acc && !ok;
    if (m_err && m_cnt < 255) m_cnt++;
    if (acc)
      $display("[TB] req cls=%0d f3=%0d rd=%0d rs1=%0d rs2=%0d imm=0x%08h -> %s 0x%08h",
               cls, funct3, rd, rs1, rs2, imm, ok ? "push" : "drop", w);
    check("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
    check("instr", instr, (m_q.size() != 0) ? m_q[0] : 32'h0);
    check("req_ready", {31'b0, req_ready}, {31'b0, m_q.size() != DEPTH});
    check("err", {31'b0, err}, {31'b0, m_err});
    check("err_cnt", {24'b0, err_cnt}, m_cnt);
  endtask

  task automatic set_req(input int c, input int f3, input int f7, input int d,
                         input int s1, input int s2, input logic [31:0] im);
    cls      = 4'(c);
    funct3   = 3'(f3);
    funct7b5 = 1'(f7);
    rd       = 5'(d);
    rs1      = 5'(s1);
    rs2      = 5'(s2);
    imm      = im;
  endtask

  // Single request into an empty FIFO with out_ready=1; word must appear next cycle
  task automatic send_dir(input string tag, input logic [31:0] exp);
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_word"}, instr, exp);
    cycle();
    check({tag, "_gone"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    m_q.delete();
    m_err = 1'b0;
    m_cnt = 0;
    check("rdy_after_rst", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_errcnt", {24'b0, err_cnt}, 32'd0);
    release_reset();

    // Directed encodings
    out_ready = 1'b1;
    set_req(5, 0, 0, 1, 0, 0, 32'd5);          send_dir("addi", 32'h00500093);
    set_req(2, 2, 0, 0, 3, 2, 32'd8);          send_dir("sw", 32'h0021A423);
    set_req(3, 0, 0, 0, 1, 2, -32'sd4);        send_dir("beq", 32'hFE208EE3);
    set_req(4, 0, 0, 1, 0, 0, 32'd8);          send_dir("jal", 32'h008000EF);
    set_req(6, 0, 0, 5, 0, 0, 32'h12345000);   send_dir("lui", 32'h123452B7);
    set_req(7, 0, 0, 0, 0, 0, 32'd1);          send_dir("ebreak", 32'h00100073);
    set_req(5, 5, 1, 3, 4, 0, 32'd7);          send_dir("srai", 32'h40725193);
    set_req(0, 0, 1, 3, 1, 2, 32'd0);          send_dir("sub", 32'h402081B3);

    // Immediate that does not fit 12 bits
    set_req(5, 0, 0, 1, 0, 0, 32'd4096);
`ifdef ENC_RANGE_CHECK_EN
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    check("range_err", {31'b0, err}, 32'd1);
    check("range_nopush", {31'b0, out_valid}, 32'd0);
    cycle();
`else
    send_dir("trunc", 32'h00000093);
`endif

    // Backpressure: fill FIFO, fifth request waits for a pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(5, 0, 0, i + 1, 0, 0, 32'(10 + i));
      req_valid = 1'b1;
      cycle();
    end
    check("bp_full", {31'b0, req_ready}, 32'd0);
    check("bp_head", instr, 32'h00A00093);
    set_req(5, 0, 0, 5, 0, 0, 32'd14);
    cycle();
    cycle();
    out_ready = 1'b1;
    cycle();
    check("bp_rdy_after_pop", {31'b0, req_ready}, 32'd1);
    check("bp_second", instr, 32'h00B00113);
    cycle();
    req_valid = 1'b0;
    for (int i = 0; i < 10 && m_q.size() != 0; i++) cycle();
    check("bp_drained", {31'b0, m_q.size() == 0}, 32'd1);

    // Illegal class: consumed, dropped, one-cycle err
    set_req(12, 0, 0, 1, 1, 1, 32'd0);
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    check("ill_err", {31'b0, err}, 32'd1);
    check("ill_cnt", {24'b0, err_cnt}, 32'd1);
    check("ill_valid", {31'b0, out_valid}, 32'd0);
    cycle();
    check("ill_err_pulse", {31'b0, err}, 32'd0);

    // Saturation of the error counter
    req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      set_req($urandom_range(10, 15), 0, 0, 0, 0, 0, 32'd0);
      cycle();
    end
    req_valid = 1'b0;
    cycle();
    check("sat_cnt", {24'b0, err_cnt}, 32'd255);

    // Reset mid-stream with three entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1, 2, 0, i + 1, 2, 0, 32'(4 * i));
      req_valid = 1'b1;
      cycle();
    end
    req_valid = 1'b0;
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_errcnt", {24'b0, err_cnt}, 32'd0);
    check("async_rst_instr", instr, 32'd0);
    release_reset();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int c;
      c = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      set_req(c, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31),
              ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4095)) - 32'd2048 : $urandom);
      req_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && m_q.size() != 0; i++) cycle();
    check("final_drained", {31'b0, m_q.size() == 0}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
